// File: rtl/drr_sched.sv
// Deficit-round-robin scheduler: merges 2**NUM_IN_LOG2 show-ahead FIFOs onto one
// 64-bit stream, forwarding whole packets in proportion to per-channel quanta.
module drr_sched #(
    parameter int NUM_IN_LOG2 = 3,
    parameter int QUANTUM_W   = 12
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [2**NUM_IN_LOG2-1:0]                   fifo_empty,
    input  logic [2**NUM_IN_LOG2-1:0][63:0]             fifo_data,
    output logic [2**NUM_IN_LOG2-1:0]                   fifo_rdreq,
    input  logic [2**NUM_IN_LOG2-1:0][QUANTUM_W-1:0]    quantum,
    input  logic                                        output_ready,
    output logic                                        output_data_valid,
    output logic [63:0]                                 output_data,
    output logic                                        output_sop,
    output logic                                        output_eop,
    output logic [NUM_IN_LOG2-1:0]                      cur_chan,
    output logic                                        busy
);
    localparam int N  = 2**NUM_IN_LOG2;
    localparam int DW = QUANTUM_W + 1;

    typedef enum logic [1:0] {SCAN, CHECK, SEND} state_t;

    state_t                 state, state_nxt;
    logic [NUM_IN_LOG2-1:0] ptr, ptr_nxt;
    logic [DW-1:0]          deficit [N];
    logic [DW-1:0]          deficit_nxt;
    logic                   deficit_we;
    logic [7:0]             remaining, remaining_nxt;
    logic [7:0]             pkt_len, pkt_len_nxt;

    logic                   head_empty;
    logic [7:0]             head_len;
    logic [DW-1:0]          head_len_ext;
    logic [DW-1:0]          cur_def;
    logic [DW:0]            def_sum;
    logic                   pop;

    // A zero length field still occupies the header word, so it counts as one.
    assign head_empty   = fifo_empty[ptr];
    assign head_len     = (fifo_data[ptr][7:0] == 8'd0) ? 8'd1 : fifo_data[ptr][7:0];
    assign head_len_ext = {{(DW-8){1'b0}}, head_len};
    assign cur_def      = deficit[ptr];
    assign def_sum      = {1'b0, cur_def} + {{(DW+1-QUANTUM_W){1'b0}}, quantum[ptr]};

    assign pop      = (state == SEND) && !head_empty && (!output_data_valid || output_ready);
    assign cur_chan = ptr;
    assign busy     = (state == SEND);

    always_comb begin
        fifo_rdreq      = '0;
        fifo_rdreq[ptr] = pop;
    end

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; an incomplete assignment here would infer a latch.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        deficit_we    = 1'b0;
        deficit_nxt   = cur_def;
        remaining_nxt = remaining;
        pkt_len_nxt   = pkt_len;
        case (state)
            SCAN: begin
                deficit_we = 1'b1;
                if (head_empty) begin
                    deficit_nxt = '0;
                    ptr_nxt     = ptr + NUM_IN_LOG2'(1);
                end else begin
                    deficit_nxt = def_sum[DW] ? '1 : def_sum[DW-1:0];
                    state_nxt   = CHECK;
                end
            end
            CHECK: begin
                if (head_empty) begin
                    deficit_we  = 1'b1;
                    deficit_nxt = '0;
                    ptr_nxt     = ptr + NUM_IN_LOG2'(1);
                    state_nxt   = SCAN;
                end else if (head_len_ext <= cur_def) begin
                    deficit_we    = 1'b1;
                    deficit_nxt   = cur_def - head_len_ext;
                    remaining_nxt = head_len;
                    pkt_len_nxt   = head_len;
                    state_nxt     = SEND;
                end else begin
                    ptr_nxt   = ptr + NUM_IN_LOG2'(1);
                    state_nxt = SCAN;
                end
            end
            SEND: begin
                // Last word returns to CHECK on the same channel without a new quantum.
                if (pop) begin
                    remaining_nxt = remaining - 8'd1;
                    if (remaining == 8'd1) state_nxt = CHECK;
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= SCAN;
            ptr               <= '0;
            remaining         <= '0;
            pkt_len           <= '0;
            output_data_valid <= 1'b0;
            output_data       <= '0;
            output_sop        <= 1'b0;
            output_eop        <= 1'b0;
            // NOTE: the deficit table is a handful of flops, not a RAM, and its
            // start value matters, so it is reset along with the control state.
            for (int i = 0; i < N; i++) deficit[i] <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            remaining <= remaining_nxt;
            pkt_len   <= pkt_len_nxt;
            if (deficit_we) deficit[ptr] <= deficit_nxt;
            if (pop) begin
                output_data       <= fifo_data[ptr];
                output_data_valid <= 1'b1;
                output_sop        <= (remaining == pkt_len);
                output_eop        <= (remaining == 8'd1);
            end else if (output_ready) begin
                output_data_valid <= 1'b0;
            end
        end
    end
endmodule
